// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   lsu_size_e      : access size encoding carried on req_size
//   lsu_state_e     : control FSM states
//   WORD_ALIGN_MASK : clears the byte-offset bits of an address
//   lane_offset()   : effective byte lane of an access after misalignment clearing
package lsu_pkg;

    typedef enum logic [1:0] {
        SizeByte = 2'b00,
        SizeHalf = 2'b01,
        SizeWord = 2'b10,
        SizeBad  = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCapture,
        StWrite,
        StResp
    } lsu_state_e;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    // Halves always start on an even lane, words on lane 0, so any stray low
    // address bits are simply dropped.
    function automatic logic [1:0] lane_offset(input lsu_size_e size, input logic [1:0] addr_lo);
        logic [1:0] off;
        case (size)
            SizeByte: off = addr_lo;
            SizeHalf: off = {addr_lo[1], 1'b0};
            default:  off = 2'b00;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit.
//   size_i       : access size (lsu_size_e encoding)
//   addr_lo_i    : byte address bits [1:0]
//   unsigned_i   : 1 = zero-extend loads, 0 = sign-extend
//   rdata_i      : word read from memory
//   wdata_i      : right-justified store data
//   load_data_o  : extracted and extended load result
//   store_data_o : rdata_i with only the addressed lanes replaced by wdata_i
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_data_o
);

    logic [1:0]  off;
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] lane_mask;

    always_comb begin
        off     = lane_offset(lsu_size_e'(size_i), addr_lo_i);
        shamt   = {off, 3'b000};
        shifted = rdata_i >> shamt;

        case (lsu_size_e'(size_i))
            SizeByte: begin
                load_data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
                lane_mask   = 32'h0000_00FF << shamt;
            end
            SizeHalf: begin
                load_data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
                lane_mask   = 32'h0000_FFFF << shamt;
            end
            default: begin
                load_data_o = rdata_i;
                lane_mask   = 32'hFFFF_FFFF;
            end
        endcase

        store_data_o = (rdata_i & ~lane_mask) | ((wdata_i << shamt) & lane_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns single CPU byte/half/word requests into word-wide
// memory accesses. Sub-word stores are done as read-modify-write.
// Optional build macro: LSU_MISALIGN_TRAP_EN -- misaligned halves/words
// complete with resp_err instead of being silently aligned down.
// Ports:
//   Clk, Rst_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready        : request handshake (ready only when idle)
//   req_we, req_size, req_unsigned, req_addr, req_wdata : request fields
//   resp_valid, resp_rdata, resp_err : one-cycle completion
//   mem_raddress, mem_dataout  : memory read port (data one cycle later)
//   mem_waddress, mem_datain, mem_wr : memory write port, full-word strobe
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_raddress,
    output logic [31:0] mem_waddress,
    output logic [31:0] mem_datain,
    input  logic [31:0] mem_dataout,
    output logic        mem_wr
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        uns_q, uns_d;
    logic        err_q, err_d;
    // Holds store data, then the merged word (stores) or extended result (loads).
    logic [31:0] data_q, data_d;

    logic        accept;
    logic        req_err;
    logic [31:0] load_word;
    logic [31:0] store_word;

    assign accept = req_valid & req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_err = (req_size == SizeBad)
                   | ((req_size == SizeHalf) & req_addr[0])
                   | ((req_size == SizeWord) & (req_addr[1:0] != 2'b00));
`else
    assign req_err = (req_size == SizeBad);
`endif

    lsu_lane_align u_lane_align (
        .size_i      (size_q),
        .addr_lo_i   (addr_q[1:0]),
        .unsigned_i  (uns_q),
        .rdata_i     (mem_dataout),
        .wdata_i     (data_q),
        .load_data_o (load_word),
        .store_data_o(store_word)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        we_d    = we_q;
        uns_d   = uns_q;
        err_d   = err_q;
        data_d  = data_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d = req_addr;
                    size_d = req_size;
                    we_d   = req_we;
                    uns_d  = req_unsigned;
                    err_d  = req_err;
                    data_d = req_wdata;
                    if (req_err) begin
                        state_d = StResp;
                    end else if (req_we && (req_size == SizeWord)) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead:    state_d = StCapture;
            StCapture: begin
                // mem_dataout now holds the word addressed during StRead.
                data_d  = we_q ? store_word : load_word;
                state_d = we_q ? StWrite : StResp;
            end
            StWrite:   state_d = StResp;
            StResp:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        req_ready    = (state_q == StIdle);
        resp_valid   = (state_q == StResp);
        resp_err     = resp_valid & err_q;
        resp_rdata   = (resp_valid & ~we_q & ~err_q) ? data_q : 32'h0;
        mem_raddress = (state_q == StRead) ? (addr_q & WORD_ALIGN_MASK) : 32'h0;
        mem_wr       = (state_q == StWrite);
        mem_waddress = mem_wr ? (addr_q & WORD_ALIGN_MASK) : 32'h0;
        mem_datain   = mem_wr ? data_q : 32'h0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a word memory with one-cycle read latency, a
// request-level reference model compared every cycle, and directed requests
// with hand-computed literal results.
module tb_load_store_unit;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_raddress;
    logic [31:0] mem_waddress;
    logic [31:0] mem_datain;
    logic [31:0] mem_dataout = 32'h0;
    logic        mem_wr;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    load_store_unit dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_raddress(mem_raddress),
        .mem_waddress(mem_waddress),
        .mem_datain  (mem_datain),
        .mem_dataout (mem_dataout),
        .mem_wr      (mem_wr)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- memory device (backdoor preload + DUT write port)
    logic [31:0] mem [1024];
    logic        bd_en = 1'b0;
    logic [31:0] bd_addr = 32'h0;
    logic [31:0] bd_data = 32'h0;
    int          wr_count = 0;
    logic [31:0] last_waddr = 32'h0;
    logic [31:0] last_wdata = 32'h0;

    always @(posedge Clk) begin
        mem_dataout <= mem[mem_raddress[11:2]];
        if (bd_en) begin
            mem[bd_addr[11:2]] <= bd_data;
        end else if (mem_wr) begin
            mem[mem_waddress[11:2]] <= mem_datain;
            wr_count   <= wr_count + 1;
            last_waddr <= mem_waddress;
            last_wdata <= mem_datain;
        end
    end

    // ---------------- reference model: one request in flight, byte-level view
    logic [31:0] refmem [1024];
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    int          m_lat = 0;
    logic        m_err = 1'b0;
    logic        m_has_rd = 1'b0;
    logic        m_has_wr = 1'b0;
    logic [9:0]  m_idx = 10'h0;
    logic [31:0] m_aligned = 32'h0;
    logic [31:0] m_wnew = 32'h0;
    logic [31:0] m_rdata = 32'h0;

    always @(posedge Clk or negedge Rst_n) begin : model
        logic [7:0]  b [4];
        logic [31:0] w;
        logic [31:0] val;
        int          off;
        int          nb;
        logic        mis;
        if (!Rst_n) begin
            m_busy = 1'b0;
            m_cnt  = 0;
        end else begin
            if (bd_en) refmem[bd_addr[11:2]] = bd_data;
            if (m_busy) begin
                // Write lands at the edge closing the write cycle; a reset before it drops it.
                if (m_has_wr && m_cnt == m_lat - 2) refmem[m_idx] = m_wnew;
                m_cnt++;
                if (m_cnt == m_lat) m_busy = 1'b0;
            end else if (req_valid) begin
                nb  = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
                mis = (req_size == 2'd1 && req_addr[0]) ||
                      (req_size == 2'd2 && req_addr[1:0] != 2'b00);
                m_err = (req_size == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
                if (mis) m_err = 1'b1;
`else
                if (mis) m_err = m_err;
`endif
                off = (req_size == 2'd0) ? int'(req_addr[1:0]) :
                      (req_size == 2'd1) ? 2 * int'(req_addr[1]) : 0;
                m_idx     = req_addr[11:2];
                m_aligned = {req_addr[31:2], 2'b00};
                w = refmem[m_idx];
                for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
                val = 32'h0;
                for (int i = 0; i < nb; i++) val[8*i +: 8] = b[off+i];
                if (!req_unsigned && nb < 4 && val[8*nb-1])
                    for (int i = nb; i < 4; i++) val[8*i +: 8] = 8'hFF;
                for (int i = 0; i < nb; i++) b[off+i] = req_wdata[8*i +: 8];
                m_wnew   = {b[3], b[2], b[1], b[0]};
                m_rdata  = (req_we || m_err) ? 32'h0 : val;
                m_has_wr = !m_err && req_we;
                m_has_rd = !m_err && (!req_we || req_size != 2'd2);
                m_lat    = m_err ? 1 : !req_we ? 3 : (req_size == 2'd2) ? 2 : 4;
                m_busy   = 1'b1;
                m_cnt    = 0;
            end
        end
    end

    // ---------------- per-cycle compare
    always @(negedge Clk) begin : compare
        logic exp_rv;
        logic exp_wr;
        if (!Rst_n) begin
            chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
            chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
            chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
            chk("rst_resp_rdata", resp_rdata, 32'h0);
            chk("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
            chk("rst_mem_raddress", mem_raddress, 32'h0);
            chk("rst_mem_waddress", mem_waddress, 32'h0);
            chk("rst_mem_datain", mem_datain, 32'h0);
        end else begin
            exp_rv = m_busy && (m_cnt == m_lat - 1);
            exp_wr = m_busy && m_has_wr && (m_cnt == m_lat - 2);
            chk("req_ready", {31'h0, req_ready}, {31'h0, !m_busy});
            chk("resp_valid", {31'h0, resp_valid}, {31'h0, exp_rv});
            if (exp_rv) begin
                chk("resp_rdata", resp_rdata, m_rdata);
                chk("resp_err", {31'h0, resp_err}, {31'h0, m_err});
            end
            chk("mem_wr", {31'h0, mem_wr}, {31'h0, exp_wr});
            if (exp_wr) begin
                chk("mem_waddress", mem_waddress, m_aligned);
                chk("mem_datain", mem_datain, m_wnew);
            end
            if (m_busy && m_has_rd && m_cnt == 0) chk("mem_raddress", mem_raddress, m_aligned);
        end
    end

    // ---------------- stimulus helpers
    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        @(negedge Clk);
        bd_en = 1'b1; bd_addr = addr; bd_data = data;
        @(negedge Clk);
        bd_en = 1'b0;
    endtask

    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int lat);
        bit got;
        @(negedge Clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        req_valid = 1'b0;
        got = 0; lat = 0; rdata = 32'h0; err = 1'b0;
        for (int n = 1; n <= 20 && !got; n++) begin
            if (resp_valid) begin
                got = 1; lat = n; rdata = resp_rdata; err = resp_err;
            end else begin
                @(negedge Clk);
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL resp_timeout: got no resp_valid expected one within 20 cycles");
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wr0;

    initial begin
        #10000000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge Clk);
        chk("reset_ready_literal", {31'h0, req_ready}, 32'h1);
        #2 Rst_n = 1'b1;
        preload(32'h100, 32'h8899AABB);

        run_req(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, rd, er, lat);
        chk("lb_signed_rdata", rd, 32'hFFFFFFAA);
        chk("lb_signed_lat", lat, 3);
        chk("lb_signed_err", {31'h0, er}, 32'h0);

        run_req(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, rd, er, lat);
        chk("lhu_rdata", rd, 32'h00008899);
        chk("lhu_lat", lat, 3);

        run_req(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, rd, er, lat);
        chk("lh_signed_rdata", rd, 32'hFFFFAABB);

        run_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, rd, er, lat);
        chk("lbu_rdata", rd, 32'h00000088);

        wr0 = wr_count;
        run_req(1'b1, 2'b00, 1'b0, 32'h102, 32'h5A, rd, er, lat);
        chk("sb_lat", lat, 4);
        chk("sb_wr_count", wr_count - wr0, 1);
        chk("sb_datain", last_wdata, 32'h885AAABB);
        chk("sb_waddr", last_waddr, 32'h100);
        chk("sb_rdata_zero", rd, 32'h0);

        wr0 = wr_count;
        run_req(1'b1, 2'b10, 1'b0, 32'h200, 32'hDEADBEEF, rd, er, lat);
        chk("sw_lat", lat, 2);
        chk("sw_wr_count", wr_count - wr0, 1);
        chk("sw_waddr", last_waddr, 32'h200);
        chk("sw_datain", last_wdata, 32'hDEADBEEF);

        wr0 = wr_count;
        run_req(1'b0, 2'b10, 1'b0, 32'h203, 32'h0, rd, er, lat);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw_mis_err", {31'h0, er}, 32'h1);
        chk("lw_mis_lat", lat, 1);
        chk("lw_mis_rdata", rd, 32'h0);
`else
        chk("lw_mis_err", {31'h0, er}, 32'h0);
        chk("lw_mis_lat", lat, 3);
        chk("lw_mis_rdata", rd, 32'hDEADBEEF);
`endif
        chk("lw_mis_no_write", wr_count - wr0, 0);

        run_req(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234, rd, er, lat);
        chk("sh_lat", lat, 4);
        run_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, rd, er, lat);
        chk("sh_readback", rd, 32'h1234BEEF);

        wr0 = wr_count;
        run_req(1'b1, 2'b11, 1'b0, 32'h100, 32'hFFFFFFFF, rd, er, lat);
        chk("illegal_st_err", {31'h0, er}, 32'h1);
        chk("illegal_st_lat", lat, 1);
        chk("illegal_st_no_write", wr_count - wr0, 0);
        run_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, rd, er, lat);
        chk("illegal_ld_err", {31'h0, er}, 32'h1);

        run_req(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, rd, er, lat);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lh_mis_err", {31'h0, er}, 32'h1);
`else
        chk("lh_mis_rdata", rd, 32'hFFFFAABB);
`endif

        // Reset while a byte store sits in its capture cycle.
        wr0 = wr_count;
        @(negedge Clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h101; req_wdata = 32'h77;
        @(posedge Clk);
        @(negedge Clk);
        req_valid = 1'b0;
        @(negedge Clk);
        #2 Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        #2 Rst_n = 1'b1;
        @(negedge Clk);
        chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
        repeat (3) @(negedge Clk);
        chk("rst_mid_no_write", wr_count - wr0, 0);
        run_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, er, lat);
        chk("rst_mid_mem_kept", rd, 32'h885AAABB);

        repeat (3) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
